adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//   Round-robin arbiter/scheduler sharing one 2-bit adder slice between NUM_REQ requesters.
//   Each requester offers an operand pair over a valid/ready handshake.
//   The block grants one requester per cycle and registers the sum with the winner's ID.
//   It returns the sum on a single response channel, also valid/ready.
//   Sits between the operand sources and the downstream result consumer.
// PARAMETERS
//   NUM_REQ  4  number of requesters, 2..8
//   OPW      2  operand width; sum is OPW+1 bits
//   CNT_W    8  width of completed-operation counter (ADDER_ARB_STATS_EN only)
// PORTS
//   clk        in   1              single clock; all state updates on rising edge
//   rst_n      in   1              synchronous, active-low reset
//   req_valid  in   NUM_REQ        per-requester operand valid
//   req_ready  out  NUM_REQ        per-requester accept; at most one bit high (one-hot or zero)
//   req_a      in   NUM_REQ*OPW    operand A, requester i at [i*OPW +: OPW]
//   req_b      in   NUM_REQ*OPW    operand B, same packing
//   rsp_valid  out  1              registered result valid
//   rsp_ready  in   1              consumer accepts result
//   rsp_sum    out  OPW+1          a+b of granted request
//   rsp_id     out  IDW            index of requester that produced rsp_sum; IDW=$clog2(NUM_REQ)
//   busy       out  1              high while rsp_valid high or any req_valid high
//   op_count   out  CNT_W          completed responses, saturating (ADDER_ARB_STATS_EN only)
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): rsp_valid=0, rsp_sum=0, rsp_id=0, op_count=0, rr_ptr=NUM_REQ-1.
//     req_ready is forced to 0 combinationally while rst_n=0.
//   - FSM states:
//     IDLE: rsp_valid=0.
//     HOLD: rsp_valid=1, result pending.
//   - can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
//   - Winner selection:
//     Search starts at the first index after rr_ptr, wrapping modulo NUM_REQ.
//     The winner is the first index with req_valid=1.
//     req_ready[winner] = can_accept; the selection is combinational.
//   - Handshake: req_valid[i] & req_ready[i] at edge T.
//     a, b and id are captured; rsp_valid=1 at T+1, so latency is 1 cycle.
//     rr_ptr <= winner.
//   - Transitions:
//     IDLE  -> HOLD on a handshake.
//     HOLD  -> IDLE on rsp_ready with no new handshake.
//     HOLD  -> HOLD on rsp_ready together with a handshake. This is back-to-back operation at 1 result/cycle.
//     HOLD with rsp_ready=0: stay in HOLD. rsp_sum and rsp_id stay stable and all req_ready=0.
//   - Requester rule: once req_valid rises, it holds valid and operands stable until its ready.
//     The arbiter never re-arbitrates away from a valid request that has not been granted.
//     Fairness bound: a valid requester waits at most NUM_REQ-1 grants.
//   - Arithmetic: rsp_sum = {1'b0,a} + {1'b0,b}, unsigned. No overflow is possible.
//     Example: 3+3 = 3'b110.
//   - Only one requester valid: it is granted every accepting cycle, regardless of rr_ptr.
//   - Reset mid-operation: a pending result is discarded and rsp_valid=0 after the edge.
//     The next grant favours requester 0.
// CONFIGURATION
//   ADDER_ARB_STATS_EN defined:
//     op_count port present.
//     Increments on each rsp_valid & rsp_ready, saturates at 2^CNT_W-1, cleared by reset.
//   ADDER_ARB_STATS_EN undefined:
//     op_count port and counter absent; all other behaviour identical.
// STRUCTURE
//   - Shared package adder_arb_pkg:
//     state encoding localparams (ST_IDLE, ST_HOLD);
//     default OPW;
//     function rr_pick(valid, ptr) returning the winner index.
//   - One sub-module: adder_slice (combinational OPW-bit adder, s = a+b, OPW+1 bits).
//     Instantiated once; driven by the muxed winner operands.
//   - Top holds FSM, rr_ptr, response registers, optional counter.
// TESTING (NUM_REQ=4, OPW=2)
//   1. rst_n=0 for 2 cycles with req_valid=4'b1111
//      -> req_ready=0, rsp_valid=0 throughout; after release, first grant req_ready=4'b0001.
//   2. Only req1 valid, a=3 b=3, rsp_ready=1
//      -> req_ready[1]=1 same cycle; next cycle rsp_valid=1, rsp_sum=3'b110, rsp_id=1.
//   3. All four valid continuously, rsp_ready=1
//      -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows 0,1,2,3 one cycle later.
//   4. Pending rsp_id=2, rsp_sum=3'b011, rsp_ready=0 for 5 cycles
//      -> output stable, req_ready=0 throughout; rsp_ready=1 releases the next grant in that cycle.
//   5. rst_n=0 asserted while HOLD
//      -> rsp_valid=0 after the edge; on release, with req3 and req0 valid, req0 is granted first.
//   6. All 16 (a,b) pairs via req2 with rsp_ready=1
//      -> every rsp_sum equals a+b; with ADDER_ARB_STATS_EN, op_count=16 at the end.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
//   Shared definitions for the adder-sharing round-robin arbiter.
//   - state_t   : response FSM encoding (ST_IDLE, ST_HOLD)
//   - OPW_DEF   : default operand width
//   - MAX_REQ   : upper bound on requesters supported by rr_pick
//   - rr_pick() : round-robin winner search starting after ptr
// -----------------------------------------------------------------------------
package adder_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam int unsigned OPW_DEF = 2;
   localparam int unsigned MAX_REQ = 8;

   // Returns the first index after ptr (wrapping modulo n) whose valid bit is
   // set. With no valid bit set the result is 0; callers qualify it with
   // |valid before use.
   function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input int unsigned         ptr,
                                           input int unsigned         n);
      int unsigned pick;
      int unsigned idx;
      logic        found;
      pick  = 0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         if ((k <= n) && !found) begin
            idx = (ptr + k) % n;
            if (valid[idx]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational unsigned adder shared by all requesters.
//   Ports:
//     a  in  W    operand A
//     b  in  W    operand B
//     s  out W+1  a + b, carry in the MSB (cannot overflow)
// -----------------------------------------------------------------------------
module adder_slice
   import adder_arb_pkg::*;
#(
   parameter int unsigned W = OPW_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   s
);

   assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//   Round-robin scheduler that shares one adder_slice between NUM_REQ
//   requesters. One operand pair is accepted per cycle over valid/ready; the
//   sum and the winner's index are registered and returned on a single
//   valid/ready response channel with one cycle of latency. Back-to-back
//   operation sustains one result per cycle.
//
//   Optional feature: define ADDER_ARB_STATS_EN to add the op_count port, a
//   saturating count of accepted responses.
//
//   Ports:
//     clk        in   1             clock, rising edge
//     rst_n      in   1             synchronous active-low reset
//     req_valid  in   NUM_REQ       per-requester operand valid
//     req_ready  out  NUM_REQ       per-requester accept, one-hot or zero
//     req_a      in   NUM_REQ*OPW   operand A, requester i at [i*OPW +: OPW]
//     req_b      in   NUM_REQ*OPW   operand B, same packing
//     rsp_valid  out  1             registered result valid
//     rsp_ready  in   1             consumer accepts result
//     rsp_sum    out  OPW+1         a+b of the granted request
//     rsp_id     out  IDW           index of the requester that produced rsp_sum
//     busy       out  1             rsp_valid or any req_valid high
//     op_count   out  CNT_W         completed responses, saturating
//                                   (ADDER_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module adder_share_arbiter
   import adder_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned OPW     = OPW_DEF,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*OPW-1:0] req_a,
   input  logic [NUM_REQ*OPW-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [OPW:0]           rsp_sum,
   output logic [IDW-1:0]         rsp_id,
   output logic                   busy
`ifdef ADDER_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]       op_count
`endif
);

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] winner;
   logic           any_valid;
   logic           can_accept;
   logic           grant;
   logic [OPW-1:0] a_sel;
   logic [OPW-1:0] b_sel;
   logic [OPW:0]   sum_w;

   assign any_valid = |req_valid;

   // A held result blocks acceptance unless the consumer drains it this cycle.
   assign can_accept = (state == ST_IDLE) || ((state == ST_HOLD) && rsp_ready);

   // Reset gates grant so req_ready is low for as long as rst_n is low.
   assign grant = rst_n && any_valid && can_accept;

   assign winner = IDW'(rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr), NUM_REQ));

   assign a_sel = req_a[winner*OPW +: OPW];
   assign b_sel = req_b[winner*OPW +: OPW];

   adder_slice #(
      .W (OPW)
   ) u_slice (
      .a (a_sel),
      .b (b_sel),
      .s (sum_w)
   );

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
         rr_ptr    <= IDW'(NUM_REQ - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state     <= ST_HOLD;
                  rsp_valid <= 1'b1;
                  rsp_sum   <= sum_w;
                  rsp_id    <= winner;
                  rr_ptr    <= winner;
               end
            end
            ST_HOLD: begin
               if (grant) begin
                  // Consumer takes the current result while the next one loads.
                  state     <= ST_HOLD;
                  rsp_valid <= 1'b1;
                  rsp_sum   <= sum_w;
                  rsp_id    <= winner;
                  rr_ptr    <= winner;
               end else if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy = rsp_valid || any_valid;

`ifdef ADDER_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (rsp_valid && rsp_ready && (op_count != '1)) begin
         op_count <= op_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned OPW     = 2;
   localparam int unsigned IDW     = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*OPW-1:0] req_a;
   logic [NUM_REQ*OPW-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [OPW:0]           rsp_sum;
   logic [IDW-1:0]         rsp_id;
   logic                   busy;
`ifdef ADDER_ARB_STATS_EN
   logic [7:0]             op_count;
`endif

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [OPW:0]   sum;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   adder_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .OPW     (OPW),
      .CNT_W   (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .busy      (busy)
`ifdef ADDER_ARB_STATS_EN
      ,
      .op_count  (op_count)
`endif
   );

   // Scoreboard consumer: every accepted response must match the oldest
   // expectation queued when its request was granted.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got id=%0d sum=%b, required no response", rsp_id, rsp_sum);
         end else begin
            e = sb.pop_front();
            if (rsp_id !== e.id || rsp_sum !== e.sum) begin
               errors++;
               $display("FAIL rsp_data: got id=%0d sum=%b, required id=%0d sum=%b",
                        rsp_id, rsp_sum, e.id, e.sum);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
      req_valid[i]      = v;
      req_a[i*OPW +: OPW] = a;
      req_b[i*OPW +: OPW] = b;
   endtask

   task automatic push(input logic [IDW-1:0] id, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
      exp_t e;
      logic [OPW:0] s;
      s = {1'b0, a};
      s = s + {1'b0, b};
      e.id  = id;
      e.sum = s;
      sb.push_back(e);
   endtask

   task automatic expect_ready(input string name, input logic [NUM_REQ-1:0] exp);
      checks++;
      if (req_ready !== exp) begin
         errors++;
         $display("FAIL %s: req_ready=%b, required %b", name, req_ready, exp);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((rsp_valid !== 1'b0 || sb.size() != 0) && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rsp_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL drain: rsp_valid=%b pending=%0d, required 0 and 0", rsp_valid, sb.size());
      end
      step();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 2'd2);
      repeat (2) begin
         step();
         @(negedge clk);
         expect_ready("reset_ready", 4'b0000);
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid: rsp_valid=%b, required 0", rsp_valid);
         end
      end
      checks++;
      if (rsp_sum !== 3'b000 || rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_regs: sum=%b id=%0d, required 000 and 0", rsp_sum, rsp_id);
      end
`ifdef ADDER_ARB_STATS_EN
      checks++;
      if (op_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_op_count: op_count=%0d, required 0", op_count);
      end
`endif
      step();
      rst_n = 1'b1;
      @(negedge clk);
      expect_ready("reset_first_grant", 4'b0001);
      push(2'd0, 2'd0, 2'd2);
      step();
      req_valid = '0;
      drain();
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      set_req(1, 1'b1, 2'd3, 2'd3);
      @(negedge clk);
      expect_ready("single_grant", 4'b0010);
      push(2'd1, 2'd3, 2'd3);
      step();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 3'b110 || rsp_id !== 2'd1) begin
         errors++;
         $display("FAIL single_rsp: valid=%b sum=%b id=%0d, required 1 110 1", rsp_valid, rsp_sum, rsp_id);
      end
      step();
      drain();
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] oh;
      int                 exp;
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 2'((i + 1) % 4));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp = k % 4;
         oh  = 4'b0001 << exp;
         expect_ready("rr_grant", oh);
         if (k > 0) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin
               errors++;
               $display("FAIL rr_rsp_id: valid=%b id=%0d, required 1 %0d", rsp_valid, rsp_id, (k - 1) % 4);
            end
         end
         push(2'(exp), 2'(exp), 2'((exp + 1) % 4));
         step();
      end
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL rr_last_id: valid=%b id=%0d, required 1 0", rsp_valid, rsp_id);
      end
      step();
      drain();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(2, 1'b1, 2'd1, 2'd2);
      @(negedge clk);
      expect_ready("hold_first_grant", 4'b0100);
      push(2'd2, 2'd1, 2'd2);
      step();
      set_req(2, 1'b0, 2'd0, 2'd0);
      set_req(0, 1'b1, 2'd2, 2'd2);
      set_req(3, 1'b1, 2'd3, 2'd1);
      repeat (5) begin
         @(negedge clk);
         expect_ready("hold_no_ready", 4'b0000);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 3'b011) begin
            errors++;
            $display("FAIL hold_stable: valid=%b id=%0d sum=%b, required 1 2 011", rsp_valid, rsp_id, rsp_sum);
         end
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      expect_ready("hold_release_grant", 4'b1000);
      push(2'd3, 2'd3, 2'd1);
      step();
      set_req(3, 1'b0, 2'd0, 2'd0);
      @(negedge clk);
      expect_ready("hold_back_to_back", 4'b0001);
      push(2'd0, 2'd2, 2'd2);
      step();
      req_valid = '0;
      drain();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      set_req(1, 1'b1, 2'd2, 2'd1);
      @(negedge clk);
      expect_ready("midrst_grant", 4'b0010);
      step();
      set_req(1, 1'b0, 2'd0, 2'd0);
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_hold: rsp_valid=%b, required 1", rsp_valid);
      end
      rst_n = 1'b0;
      set_req(0, 1'b1, 2'd1, 2'd1);
      set_req(3, 1'b1, 2'd2, 2'd3);
      @(negedge clk);
      expect_ready("midrst_ready_low", 4'b0000);
      step();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_discard: rsp_valid=%b, required 0", rsp_valid);
      end
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      expect_ready("midrst_req0_first", 4'b0001);
      push(2'd0, 2'd1, 2'd1);
      step();
      set_req(0, 1'b0, 2'd0, 2'd0);
      @(negedge clk);
      expect_ready("midrst_req3_next", 4'b1000);
      push(2'd3, 2'd2, 2'd3);
      step();
      req_valid = '0;
      drain();
   endtask

   task automatic test_all_sums();
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            set_req(2, 1'b1, 2'(a), 2'(b));
            @(negedge clk);
            expect_ready("sums_grant", 4'b0100);
            push(2'd2, 2'(a), 2'(b));
            step();
         end
      end
      req_valid = '0;
      drain();
`ifdef ADDER_ARB_STATS_EN
      checks++;
      if (op_count !== 8'd16) begin
         errors++;
         $display("FAIL sums_op_count: op_count=%0d, required 16", op_count);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_all_sums();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
